dmem_arbiter: RTL and testbench

Two-requester arbiter for the single data-memory port. It sits between the core's load/store unit (port 0) and the debug/program-loader port (port 1) on one side, and the byte-addressed data RAM with its `mem_u_b_h_w` width encoding on the other. It grants one access at a time round-robin, latches the winning request, drives the RAM for exactly one cycle and returns registered read data with a one-cycle valid pulse.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - mem_u_b_h_w width encoding constants (bit0 half, bit1 word, bit2 unsigned)
//   - simulation UART address (exempt from the alignment check)
//   - arbiter FSM state encoding
//   - misaligned(): alignment helper used when DMEM_ARB_MISALIGN_CHK_EN is defined
package dmem_pkg;

  localparam logic [2:0]  W_B   = 3'b000;
  localparam logic [2:0]  W_H   = 3'b001;
  localparam logic [2:0]  W_W   = 3'b010;
  localparam int          U_BIT = 2;

  localparam logic [31:0] SIM_UART_ADDR = 32'h1000_0000;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } dmem_state_e;

  // True when a half access has addr[0] set or a word access has addr[1:0]
  // nonzero. The UART address is never flagged. Encoding 3'b011 decodes as a
  // word, the same way the RAM decodes it.
  function automatic logic misaligned(input logic [31:0] addr,
                                      input logic [2:0]  width);
    logic [2:0] kind;
    logic       bad;
    kind = width & ~(3'b001 << U_BIT);
    case (kind)
      W_B:     bad = 1'b0;
      W_H:     bad = addr[0];
      W_W:     bad = |addr[1:0];
      default: bad = |addr[1:0];
    endcase
    if (addr == SIM_UART_ADDR) begin
      bad = 1'b0;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0]  in   per-port request
//   prio      in   preferred port when both request (0 = port 0)
//   win[1:0]  out  one-hot winner, 0 when nobody requests
//   any       out  at least one request present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] win,
  output logic       any
);

  // Pick the winner; the pointer only matters when both ports request.
  always_comb begin
    win = 2'b00;
    any = |req;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11: begin
        if (prio) begin
          win = 2'b10;
        end else begin
          win = 2'b01;
        end
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter for the single data-RAM
// port. Port 0 is the load/store unit, port 1 the debug/program loader.
// A grant latches the winning request; the RAM is driven for exactly one
// ACCESS cycle and the result comes back registered one cycle later.
//
// Optional feature: define DMEM_ARB_MISALIGN_CHK_EN to suppress writes for
// misaligned half/word accesses and report them through rerr.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req[1:0]               per-port request, held until gnt
//   addr0/1, we[1:0]       byte address, store enable
//   wdata0/1, width0/1     store data, mem_u_b_h_w width encoding
//   gnt[1:0]               one-hot accept pulse (combinational, IDLE only)
//   rvalid[1:0], rdata     completion pulse and load data (0 for stores)
//   rerr                   misaligned-access flag, valid with rvalid
//   ram_addr/din/we/width  RAM-side command, ram_dout combinational read data
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [1:0]  we,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  width0,
  input  logic [2:0]  width1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic        rerr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_width,
  input  logic [31:0] ram_dout
);

  dmem_state_e state_r;
  dmem_state_e state_s;

  logic        prio_r;
  logic [1:0]  win_s;
  logic        any_s;
  logic        grant_s;

  logic        sel_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [2:0]  sel_width_s;
  logic        sel_we_s;
  logic        sel_mis_s;

  logic        port_r;
  logic        we_r;
  logic        mis_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  width_r;

  logic [1:0]  rvalid_r;
  logic [31:0] rdata_r;
  logic        rerr_r;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .prio (prio_r),
    .win  (win_s),
    .any  (any_s)
  );

  // Next state and grant; a grant can only be issued from IDLE.
  always_comb begin
    state_s = state_r;
    gnt     = 2'b00;
    grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          gnt     = win_s;
          grant_s = 1'b1;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Steer the winning port's request fields toward the latches.
  always_comb begin
    sel_s = win_s[1];
    if (sel_s) begin
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
      sel_width_s = width1;
      sel_we_s    = we[1];
    end else begin
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
      sel_width_s = width0;
      sel_we_s    = we[0];
    end
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  assign sel_mis_s = misaligned(sel_addr_s, sel_width_s);
`else
  assign sel_mis_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latches and round-robin pointer, updated on every grant.
  // The latches also hold the RAM command steady outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r  <= 1'b0;
      port_r  <= 1'b0;
      we_r    <= 1'b0;
      mis_r   <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      width_r <= 3'b000;
    end else if (grant_s) begin
      prio_r  <= ~sel_s;
      port_r  <= sel_s;
      we_r    <= sel_we_s;
      mis_r   <= sel_mis_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
      width_r <= sel_width_s;
    end else begin
      prio_r  <= prio_r;
      port_r  <= port_r;
      we_r    <= we_r;
      mis_r   <= mis_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      width_r <= width_r;
    end
  end

  // Completion: capture RAM read data at the end of ACCESS and pulse rvalid.
  // rdata and rerr hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= 2'b00;
      rdata_r  <= 32'h0000_0000;
      rerr_r   <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      rvalid_r <= port_r ? 2'b10 : 2'b01;
      rerr_r   <= mis_r;
      if (we_r || mis_r) begin
        rdata_r <= 32'h0000_0000;
      end else begin
        rdata_r <= ram_dout;
      end
    end else begin
      rvalid_r <= 2'b00;
      rdata_r  <= rdata_r;
      rerr_r   <= rerr_r;
    end
  end

  // ram_we is decoded from the state so an asynchronous reset kills it at once.
  assign ram_we    = (state_r == ST_ACCESS) && we_r && !mis_r;
  assign ram_addr  = addr_r;
  assign ram_din   = wdata_r;
  assign ram_width = width_r;

  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign rerr   = rerr_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-addressed RAM
// model (combinational read with mem_u_b_h_w extension, negedge write, writes
// to the UART address do not touch memory). Expected values are hand-computed.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] addr0, addr1;
  logic [1:0]  we;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  width0, width1;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        rerr;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [2:0]  ram_width;
  logic [31:0] ram_dout;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .we        (we),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .width0    (width0),
    .width1    (width1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rerr      (rerr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_width (ram_width),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [0:255];
  logic [7:0] idx, b0, b1, b2, b3;
  assign idx = ram_addr[7:0];
  assign b0  = mem[idx];
  assign b1  = mem[idx + 8'd1];
  assign b2  = mem[idx + 8'd2];
  assign b3  = mem[idx + 8'd3];

  always_comb begin
    case (ram_width[1:0])
      2'b00:   ram_dout = ram_width[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   ram_dout = ram_width[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ram_dout = {b3, b2, b1, b0};
    endcase
  end

  always @(negedge clk) begin
    if (ram_we && ram_addr != SIM_UART_ADDR) begin
      mem[idx] <= ram_din[7:0];
      if (ram_width[0] | ram_width[1]) mem[idx + 8'd1] <= ram_din[15:8];
      if (ram_width[1]) begin
        mem[idx + 8'd2] <= ram_din[23:16];
        mem[idx + 8'd3] <= ram_din[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on a single port, starting in IDLE at edge+1.
  task automatic issue(input string tag, input int p, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] wd,
                       input logic exp_we, input logic [31:0] exp_rd, input logic exp_err);
    logic [1:0] onehot;
    onehot = (p == 1) ? 2'b10 : 2'b01;
    if (p == 1) begin
      addr1 = a; wdata1 = d; width1 = wd; we[1] = w;
    end else begin
      addr0 = a; wdata0 = d; width0 = wd; we[0] = w;
    end
    req = onehot;
    #1;
    chk({tag, "_gnt"}, {30'h0, gnt}, {30'h0, onehot});
    tick();
    req = 2'b00;
    chk({tag, "_ram_we"}, {31'h0, ram_we}, {31'h0, exp_we});
    chk({tag, "_ram_addr"}, ram_addr, a);
    chk({tag, "_ram_width"}, {29'h0, ram_width}, {29'h0, wd});
    chk({tag, "_acc_gnt"}, {30'h0, gnt}, 32'h0);
    tick();
    chk({tag, "_rvalid"}, {30'h0, rvalid}, {30'h0, onehot});
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_rerr"}, {31'h0, rerr}, {31'h0, exp_err});
  endtask

  logic [1:0]  exp_g, exp_v;
  logic [31:0] exp_d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 32) ? i[7:0] : 8'h00;
    mem[8'h21] = 8'h80;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    width0 = W_B; width1 = W_B;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rerr", {31'h0, rerr}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    chk("rst_ram_width", {29'h0, ram_width}, 32'h0);
    tick();

    // Both ports requesting continuously: grants 0,1,0,1 two cycles apart
    addr0 = 32'h0; addr1 = 32'h4; width0 = W_W; width1 = W_W; we = 2'b00;
    req = 2'b11;
    for (int k = 0; k < 9; k++) begin
      if (k == 7) req = 2'b00;
      #1;
      exp_g = (k % 2 == 0 && k <= 6) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_v = (k % 2 == 0 && k >= 2) ? ((((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("rr_gnt_c%0d", k), {30'h0, gnt}, {30'h0, exp_g});
      chk($sformatf("rr_rvalid_c%0d", k), {30'h0, rvalid}, {30'h0, exp_v});
      if (exp_v != 2'b00) begin
        exp_d = exp_v[0] ? 32'h0302_0100 : 32'h0706_0504;
        chk($sformatf("rr_rdata_c%0d", k), rdata, exp_d);
      end
      tick();
    end

    // Port 0 store word then back-to-back load of the same word
    addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF; width0 = W_W; we[0] = 1'b1; req = 2'b01;
    #1;
    chk("sl_c0_gnt", {30'h0, gnt}, 32'h1);
    tick();
    we[0] = 1'b0;
    chk("sl_c1_gnt", {30'h0, gnt}, 32'h0);
    chk("sl_c1_ram_we", {31'h0, ram_we}, 32'h1);
    chk("sl_c1_ram_addr", ram_addr, 32'h10);
    chk("sl_c1_ram_din", ram_din, 32'hDEAD_BEEF);
    tick();
    chk("sl_c2_rvalid", {30'h0, rvalid}, 32'h1);
    chk("sl_c2_rdata", rdata, 32'h0);
    chk("sl_c2_gnt", {30'h0, gnt}, 32'h1);
    tick();
    req = 2'b00;
    chk("sl_c3_ram_we", {31'h0, ram_we}, 32'h0);
    chk("sl_c3_rvalid", {30'h0, rvalid}, 32'h0);
    tick();
    chk("sl_c4_rvalid", {30'h0, rvalid}, 32'h1);
    chk("sl_c4_rdata", rdata, 32'hDEAD_BEEF);
    chk("sl_c4_rerr", {31'h0, rerr}, 32'h0);
    tick();
    chk("sl_c5_ram_addr_hold", ram_addr, 32'h10);

    // Signed and unsigned byte loads
    issue("ldsb", 0, 1'b0, 32'h21, 32'h0, 3'b000, 1'b0, 32'hFFFF_FF80, 1'b0);
    issue("ldub", 0, 1'b0, 32'h21, 32'h0, 3'b100, 1'b0, 32'h0000_0080, 1'b0);

    // Port 1 byte store to the UART, then confirm RAM byte 0 untouched
    issue("uart", 1, 1'b1, SIM_UART_ADDR, 32'h41, W_B, 1'b1, 32'h0, 1'b0);
    issue("uart_rb", 0, 1'b0, 32'h0, 32'h0, 3'b100, 1'b0, 32'h0, 1'b0);

    // Misaligned word store
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    issue("mis", 0, 1'b1, 32'h22, 32'h1234_5678, W_W, 1'b0, 32'h0, 1'b1);
`else
    issue("mis", 0, 1'b1, 32'h22, 32'h1234_5678, W_W, 1'b1, 32'h0, 1'b0);
`endif

    // Reset landing in the ACCESS cycle of a store
    addr0 = 32'h30; wdata0 = 32'hCAFE_F00D; width0 = W_W; we[0] = 1'b1; req = 2'b01;
    #1;
    chk("ra_gnt", {30'h0, gnt}, 32'h1);
    tick();
    req = 2'b00;
    rst = 1'b1;
    #1;
    chk("ra_ram_we", {31'h0, ram_we}, 32'h0);
    tick();
    rst = 1'b0;
    chk("ra_rvalid", {30'h0, rvalid}, 32'h0);
    chk("ra_ram_addr", ram_addr, 32'h0);
    tick();
    chk("ra_rvalid2", {30'h0, rvalid}, 32'h0);
    // Pointer back at port 0: both request, port 0 wins
    we = 2'b00; addr0 = 32'h30; addr1 = 32'h0; width1 = W_W;
    req = 2'b11;
    #1;
    chk("ra_prio_gnt", {30'h0, gnt}, 32'h1);
    tick();
    req = 2'b00;
    tick();
    chk("ra_lost_rvalid", {30'h0, rvalid}, 32'h1);
    chk("ra_lost_rdata", rdata, 32'h0);
    // Pointer now prefers port 1, but a lone port 0 request still wins
    issue("solo", 0, 1'b0, 32'h4, 32'h0, W_W, 1'b0, 32'h0706_0504, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
